// File: rtl/proc_gen.sv
`default_nettype none
// ============================================================================
// Module   : proc_gen
// Purpose  : Multi-cycle processor with register file, single-port memory
//            interface and a valid/ready output channel.
// Revision : 1.0 - initial release
// ============================================================================
module proc_gen #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       fromMem,
    output logic              we,
    output logic [15:0]       addr,
    output logic [15:0]       toMem,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              halted,
    output logic              illegal
);
    localparam int IDX_W = $clog2(NREGS);

    localparam logic [4:0]  OP_NOP    = 5'b00000;
    localparam logic [4:0]  OP_OUTLOC = 5'b00001;
    localparam logic [4:0]  OP_OUTR   = 5'b00010;
    localparam logic [4:0]  OP_STR    = 5'b00011;
    localparam logic [4:0]  OP_ADD    = 5'b00100;
    localparam logic [4:0]  OP_SUB    = 5'b00101;
    localparam logic [4:0]  OP_JMP    = 5'b00110;
    localparam logic [4:0]  OP_BZ     = 5'b00111;
    localparam logic [15:0] IR_HALT   = 16'h7777;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM_READ  = 3'd3,
        S_MEM_WRITE = 3'd4,
        S_OUT_WAIT  = 3'd5,
        S_HALT      = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [15:0]       addr_q, addr_d;
    logic [DATA_W-1:0] tomem_q, tomem_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              we_q, we_d;
    logic              halted_q, halted_d;
    logic              illegal_q, illegal_d;
    logic [DATA_W-1:0] regs_q [NREGS];

    logic              rf_we;
    logic [IDX_W-1:0]  rf_idx;
    logic [DATA_W-1:0] rf_wdata;

    logic [4:0]        opcode;
    logic [ADDR_W-1:0] fld_a;
    logic [IDX_W-1:0]  idx_s, idx_d, idx_li;
    logic [DATA_W-1:0] rs_val, rd_val;
    logic [ADDR_W-1:0] pc_inc;

    function automatic logic [15:0] pc_to_addr(input logic [ADDR_W-1:0] p);
        pc_to_addr = 16'(p);
    endfunction

    assign opcode = ir_q[15:11];
    assign fld_a  = ir_q[ADDR_W-1:0];
    assign idx_s  = ir_q[IDX_W-1:0];
    assign idx_d  = ir_q[5 +: IDX_W];
    assign idx_li = ir_q[8 +: IDX_W];
    assign rs_val = regs_q[idx_s];
    assign rd_val = regs_q[idx_d];
    assign pc_inc = pc_q + ADDR_W'(1);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        addr_d      = addr_q;
        tomem_d     = tomem_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        we_d        = 1'b0;
        halted_d    = halted_q;
        illegal_d   = 1'b0;
        rf_we       = 1'b0;
        rf_idx      = idx_d;
        rf_wdata    = rd_val + rs_val;

        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                ir_d    = fromMem;
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                state_d = S_FETCH;
                pc_d    = pc_inc;
                addr_d  = pc_to_addr(pc_inc);
                if (ir_q == IR_HALT) begin
                    state_d  = S_HALT;
                    pc_d     = pc_q;
                    addr_d   = addr_q;
                    halted_d = 1'b1;
                end else begin
                    casez (opcode)
                        OP_NOP: begin
                        end
                        OP_OUTLOC: begin
                            state_d = S_MEM_READ;
                            pc_d    = pc_q;
                            addr_d  = addr_q;
                        end
                        OP_OUTR: begin
                            out_data_d  = rs_val;
                            out_valid_d = 1'b1;
                            state_d     = S_OUT_WAIT;
                            pc_d        = pc_q;
                            addr_d      = addr_q;
                        end
                        OP_STR: begin
                            addr_d  = 16'(rd_val);
                            tomem_d = rs_val;
                            we_d    = 1'b1;
                            state_d = S_MEM_WRITE;
                            pc_d    = pc_q;
                        end
                        OP_ADD: rf_we = 1'b1;
                        OP_SUB: begin
                            rf_we    = 1'b1;
                            rf_wdata = rd_val - rs_val;
                        end
                        OP_JMP: begin
                            pc_d   = fld_a;
                            addr_d = pc_to_addr(fld_a);
                        end
                        OP_BZ: begin
                            pc_d   = (rs_val == '0) ? pc_q + ADDR_W'(2) : pc_inc;
                            addr_d = pc_to_addr(pc_d);
                        end
                        5'b110??: begin
                            rf_we    = 1'b1;
                            rf_idx   = idx_li;
                            rf_wdata = DATA_W'(ir_q[7:0]);
                        end
                        default: illegal_d = 1'b1;
                    endcase
                end
            end
            S_MEM_READ: begin
                out_data_d  = fromMem[DATA_W-1:0];
                out_valid_d = 1'b1;
                state_d     = S_OUT_WAIT;
            end
            S_MEM_WRITE: begin
                state_d = S_FETCH;
                pc_d    = pc_inc;
                addr_d  = pc_to_addr(pc_inc);
            end
            S_OUT_WAIT: begin
                out_valid_d = 1'b1;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_FETCH;
                    pc_d        = pc_inc;
                    addr_d      = pc_to_addr(pc_inc);
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            addr_q      <= '0;
            tomem_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            we_q        <= 1'b0;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            addr_q      <= addr_d;
            tomem_q     <= tomem_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            we_q        <= we_d;
            halted_q    <= halted_d;
            illegal_q   <= illegal_d;
            if (rf_we) regs_q[rf_idx] <= rf_wdata;
        end
    end

    // OUTLOC presents its operand address during EXECUTE so the data returns in MEM_READ
    assign addr      = (state_q == S_EXECUTE && opcode == OP_OUTLOC) ? pc_to_addr(fld_a) : addr_q;
    assign toMem     = 16'(tomem_q);
    assign we        = we_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign halted    = halted_q;
    assign illegal   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_proc_gen.sv
`default_nettype none
// Bench for proc_gen: directed scenarios plus randomized programs compared
// against an instruction-level reference model.
module tb_proc_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1, rst_b = 1'b1, out_ready = 1'b0;
    logic [15:0] rd_a, rd_b, addr_a, addr_b, tomem_a, tomem_b;
    logic [7:0]  od_a, od_b;
    logic        we_a, we_b, ov_a, ov_b, halt_a, halt_b, ill_a, ill_b;

    proc_gen u_dut (
        .clk(clk), .rst(rst_a), .fromMem(rd_a), .we(we_a), .addr(addr_a),
        .toMem(tomem_a), .out_data(od_a), .out_valid(ov_a), .out_ready(out_ready),
        .halted(halt_a), .illegal(ill_a)
    );

    proc_gen #(.DATA_W(8), .NREGS(32), .ADDR_W(4)) u_dut4 (
        .clk(clk), .rst(rst_b), .fromMem(rd_b), .we(we_b), .addr(addr_b),
        .toMem(tomem_b), .out_data(od_b), .out_valid(ov_b), .out_ready(out_ready),
        .halted(halt_b), .illegal(ill_b)
    );

    // Synchronous memories: data for an address appears in the following cycle
    logic [15:0] mem_a [2048];
    logic [15:0] mem_b [16];
    logic        mclr = 1'b0, mld = 1'b0;
    logic [10:0] mld_addr = '0;
    logic [15:0] mld_data = '0;

    always @(posedge clk) begin
        if (mclr) begin
            for (int i = 0; i < 2048; i++) mem_a[i] <= '0;
            for (int i = 0; i < 16; i++) mem_b[i] <= '0;
        end else if (mld) begin
            mem_a[mld_addr]      <= mld_data;
            mem_b[mld_addr[3:0]] <= mld_data;
        end else begin
            if (we_a) mem_a[addr_a[10:0]] <= tomem_a;
            if (we_b) mem_b[addr_b[3:0]]  <= tomem_b;
        end
        rd_a <= mem_a[addr_a[10:0]];
        rd_b <= mem_b[addr_b[3:0]];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [15:0] d);
        mld = 1'b1; mld_addr = 11'(a); mld_data = d;
        tick();
        mld = 1'b0;
    endtask

    task automatic start();
        rst_a = 1'b1; rst_b = 1'b1; mclr = 1'b1;
        tick();
        mclr = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int k = 0;
        while (!ov_a && k < budget) begin
            tick();
            k++;
        end
        check({tag, "_valid_seen"}, 32'(ov_a), 1);
    endtask

    // ---------------- instruction-level reference model ----------------
    logic [15:0] img [256];
    logic [7:0]  q_out [$];
    logic [31:0] q_wr  [$];

    task automatic gen_prog();
        int p = 0;
        int kind, op;
        logic [15:0] w;
        for (int i = 0; i < 256; i++) img[i] = (i >= 128) ? 16'($urandom) : 16'h0000;
        img[p] = {3'b110, 5'd31, 8'h80 | 8'($urandom_range(0, 127))}; p++;
        while (p < 100) begin
            kind = $urandom_range(0, 9);
            case (kind)
                0: w = {3'b110, 5'($urandom_range(0, 30)), 8'($urandom)};
                1: w = {5'b00100, 1'($urandom), 5'($urandom_range(0, 30)), 5'($urandom)};
                2: w = {5'b00101, 1'($urandom), 5'($urandom_range(0, 30)), 5'($urandom)};
                3: w = {5'b00010, 6'($urandom), 5'($urandom)};
                4: w = {5'b00001, 11'($urandom_range(128, 255))};
                5: begin
                    img[p] = {3'b110, 5'd31, 8'h80 | 8'($urandom_range(0, 127))}; p++;
                    w = {5'b00011, 1'($urandom), 5'd31, 5'($urandom)};
                end
                6: w = 16'h0000;
                7: begin
                    op = $urandom_range(8, 31);
                    if (op >= 24 && op <= 27) op = op - 16;
                    w = {5'(op), 11'($urandom)};
                    if (w == 16'h7777) w = 16'h7776;
                end
                8: w = {5'b00111, 6'($urandom), 5'($urandom)};
                default: w = {5'b00110, 11'(p + 2)};
            endcase
            img[p] = w; p++;
        end
        img[p] = 16'h7777;
        img[p+1] = 16'h7777;
    endtask

    task automatic model(output int cycles, output int n_ill);
        logic [15:0] m [2048];
        logic [7:0]  r [32];
        logic [10:0] pc, nxt;
        logic [15:0] ir;
        logic [4:0]  op, rd, rs;
        for (int i = 0; i < 2048; i++) m[i] = (i < 256) ? img[i] : 16'h0000;
        for (int i = 0; i < 32; i++) r[i] = 8'h00;
        q_out.delete(); q_wr.delete();
        pc = '0; cycles = 0; n_ill = 0;
        for (int s = 0; s < 2000; s++) begin
            ir = m[pc]; op = ir[15:11]; rd = ir[9:5]; rs = ir[4:0];
            cycles += 3;
            if (ir == 16'h7777) break;
            nxt = pc + 11'd1;
            if (op == 5'd1) begin
                q_out.push_back(m[ir[10:0]][7:0]);
                cycles += 1;
            end else if (op == 5'd2) q_out.push_back(r[rs]);
            else if (op == 5'd3) begin
                q_wr.push_back({8'h00, r[rd], 8'h00, r[rs]});
                m[{3'b000, r[rd]}] = {8'h00, r[rs]};
                cycles += 1;
            end else if (op == 5'd4) r[rd] = r[rd] + r[rs];
            else if (op == 5'd5) r[rd] = r[rd] - r[rs];
            else if (op == 5'd6) nxt = ir[10:0];
            else if (op == 5'd7) begin
                if (r[rs] == 8'h00) nxt = pc + 11'd2;
            end else if (op[4:2] == 3'b110) r[ir[12:8]] = ir[7:0];
            else if (op != 5'd0) n_ill++;
            pc = nxt;
        end
    endtask

    task automatic run_random();
        int exp_cyc, exp_ill, cyc, waits, ills;
        logic [7:0]  prev;
        logic        prev_wait;
        logic [31:0] w;
        gen_prog();
        model(exp_cyc, exp_ill);
        start();
        for (int i = 0; i < 256; i++) load(i, img[i]);
        rst_a = 1'b0;
        cyc = 0; waits = 0; ills = 0; prev_wait = 1'b0; prev = '0;
        while (!halt_a && cyc < 5000) begin
            out_ready = 1'($urandom_range(0, 1));
            if (ov_a) begin
                waits++;
                if (prev_wait) check("rnd_hold", 32'(od_a), 32'(prev));
                if (out_ready) begin
                    if (q_out.size() == 0) check("rnd_extra_out", 1, 0);
                    else check("rnd_out", 32'(od_a), 32'(q_out.pop_front()));
                end
            end
            prev_wait = ov_a && !out_ready;
            prev = od_a;
            if (we_a) begin
                if (q_wr.size() == 0) check("rnd_extra_wr", 1, 0);
                else begin
                    w = q_wr.pop_front();
                    check("rnd_wr_addr", 32'(addr_a), 32'(w[31:16]));
                    check("rnd_wr_data", 32'(tomem_a), 32'(w[15:0]));
                end
            end
            if (ill_a) ills++;
            tick();
            cyc++;
        end
        check("rnd_halted", 32'(halt_a), 1);
        check("rnd_cycles", cyc, exp_cyc + waits);
        check("rnd_outs_left", q_out.size(), 0);
        check("rnd_wr_left", q_wr.size(), 0);
        check("rnd_illegal", ills, exp_ill);
        rst_a = 1'b1;
    endtask

    initial begin
        int cnt, at;

        // LI r8,5 ; OUTR r8 -> single-cycle valid at cycle 6
        start();
        load(0, 16'hC805); load(1, 16'h1008); load(2, 16'h7777);
        check("rst_we", 32'(we_a), 0);
        check("rst_addr", 32'(addr_a), 0);
        check("rst_tomem", 32'(tomem_a), 0);
        check("rst_out_data", 32'(od_a), 0);
        check("rst_out_valid", 32'(ov_a), 0);
        check("rst_halted", 32'(halt_a), 0);
        check("rst_illegal", 32'(ill_a), 0);
        out_ready = 1'b1;
        rst_a = 1'b0;
        repeat (5) tick();
        check("t034_valid_c5", 32'(ov_a), 0);
        tick();
        check("t034_valid_c6", 32'(ov_a), 1);
        check("t034_data", 32'(od_a), 32'h05);
        tick();
        check("t034_valid_c7", 32'(ov_a), 0);

        // 8-bit wrap on ADD
        start();
        load(0, 16'hC1FF); load(1, 16'hC202); load(2, 16'h2022);
        load(3, 16'h1001); load(4, 16'h7777);
        out_ready = 1'b1;
        rst_a = 1'b0;
        wait_valid("t035", 40);
        check("t035_data", 32'(od_a), 32'h01);

        // consumer stall: output and pc held until ready
        start();
        load(0, 16'hC53C); load(1, 16'h1005); load(2, 16'h0000); load(3, 16'h7777);
        out_ready = 1'b0;
        rst_a = 1'b0;
        wait_valid("t036", 30);
        for (int i = 0; i < 10; i++) begin
            check("t036_hold_valid", 32'(ov_a), 1);
            check("t036_hold_data", 32'(od_a), 32'h3C);
            check("t036_hold_pc", 32'(addr_a), 32'h0001);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("t036_released", 32'(ov_a), 0);
        check("t036_next_pc", 32'(addr_a), 32'h0002);

        // STR: single write strobe with register address and data
        start();
        load(0, 16'hC3AA); load(1, 16'hC440); load(2, 16'h1883); load(3, 16'h7777);
        rst_a = 1'b0;
        cnt = 0; at = -1;
        for (int c = 0; c < 20; c++) begin
            if (we_a) begin
                cnt++; at = c;
                check("t037_addr", 32'(addr_a), 32'h0040);
                check("t037_tomem", 32'(tomem_a), 32'h00AA);
            end
            tick();
        end
        check("t037_we_count", cnt, 1);
        check("t037_we_cycle", at, 9);

        // undefined opcode: pulse, pc+1, registers intact
        start();
        load(0, 16'hC011); load(1, 16'h4000); load(2, 16'h1000); load(3, 16'h7777);
        out_ready = 1'b1;
        rst_a = 1'b0;
        cnt = 0; at = -1;
        for (int c = 0; c < 8; c++) begin
            if (ill_a) begin
                cnt++; at = c;
                check("t039_pc_after", 32'(addr_a), 32'h0002);
            end
            tick();
        end
        check("t039_pulse_count", cnt, 1);
        check("t039_pulse_cycle", at, 6);
        wait_valid("t039", 30);
        check("t039_reg_kept", 32'(od_a), 32'h11);

        // ADDR_W=4: pc wrap, halt freeze, reset clears
        start();
        load(0, 16'h300F); load(15, 16'h0000);
        rst_b = 1'b0;
        check("t038_pc0", 32'(addr_b), 32'h0000);
        tick(); tick();
        load(0, 16'h7777);
        check("t038_jmp15", 32'(addr_b), 32'h000F);
        repeat (3) tick();
        check("t038_wrap", 32'(addr_b), 32'h0000);
        repeat (3) tick();
        check("t038_halted", 32'(halt_b), 1);
        for (int i = 0; i < 5; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            check("t038_halt_hold", 32'(halt_b), 1);
            check("t038_pc_frozen", 32'(addr_b), 32'h0000);
            check("t038_no_we", 32'(we_b), 0);
        end
        rst_b = 1'b1;
        tick();
        check("t038_rst_halted", 32'(halt_b), 0);
        check("t038_rst_addr", 32'(addr_b), 0);
        check("t038_rst_we", 32'(we_b), 0);
        check("t038_rst_tomem", 32'(tomem_b), 0);
        check("t038_rst_valid", 32'(ov_b), 0);
        check("t038_rst_data", 32'(od_b), 0);
        check("t038_rst_illegal", 32'(ill_b), 0);

        for (int k = 0; k < 4; k++) run_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/proc_gen.md
PROC_GEN -- requirements
Module: proc_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning register/output data width (legal 8..16).
REQ-002 SHALL have parameter NREGS, default 32, meaning register count (power of two, 2..32).
REQ-003 SHALL have parameter ADDR_W, default 11, meaning pc/address width (legal 4..11); addr upper bits above ADDR_W driven 0.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port fromMem  input  16  memory read data, valid in the cycle after addr is driven.
REQ-007 SHALL have port we  output  1  memory write strobe.
REQ-008 SHALL have port addr  output  16  memory address.
REQ-009 SHALL have port toMem  output  16  memory write data, zero-extended from DATA_W.
REQ-010 SHALL have port out_data  output  DATA_W  output-channel data.
REQ-011 SHALL have port out_valid  output  1  out_data valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts out_data.
REQ-013 SHALL have port halted  output  1  processor stopped by HALT.
REQ-014 SHALL have port illegal  output  1  one-cycle pulse on undefined opcode.

Function
REQ-015 SHALL hold 16-bit ir, ADDR_W-bit pc, NREGS x DATA_W register file; register index = field low log2(NREGS) bits.
REQ-016 SHALL run FSM FETCH->DECODE->EXECUTE, then MEM_READ, MEM_WRITE, OUT_WAIT, HALT or FETCH per opcode.
REQ-017 SHALL, in FETCH, drive addr=pc; in DECODE, load ir=fromMem.
REQ-018 SHALL decode opcode ir[15:11]: 00000 NOP; 00001 OUTLOC a=ir[10:0]; 00010 OUTR rs=ir[4:0]; 00011 STR ra=ir[9:5], rs=ir[4:0]; 00100 ADD rd=ir[9:5], rs=ir[4:0]; 00101 SUB same fields; 00110 JMP a=ir[10:0]; 00111 BZ rs=ir[4:0]; 110xx LI rd=ir[12:8], imm=ir[7:0]; ir==16'h7777 HALT.
REQ-019 SHALL execute LI as rd<=zero-extended imm (truncated if DATA_W<8 impossible; upper bits 0).
REQ-020 SHALL execute ADD/SUB as rd<=rd+/-rs modulo 2^DATA_W, no flags, wrap silently.
REQ-021 SHALL execute JMP as pc<=a[ADDR_W-1:0]; BZ as pc<=pc+2 if reg[rs]==0 else pc+1.
REQ-022 SHALL, for all other completed instructions, set pc<=pc+1 modulo 2^ADDR_W (wrap to 0) and addr<=next pc.
REQ-023 SHALL execute OUTLOC: EXECUTE drives addr=a; MEM_READ captures fromMem[DATA_W-1:0] to out_data, enters OUT_WAIT.
REQ-024 SHALL execute OUTR: EXECUTE captures reg[rs] to out_data, enters OUT_WAIT.
REQ-025 SHALL hold out_valid=1 and out_data stable throughout OUT_WAIT; leave to FETCH with pc+1 on the cycle out_valid&&out_ready.
REQ-026 SHALL execute STR: EXECUTE registers addr=reg[ra] zero-extended, toMem=reg[rs]; MEM_WRITE asserts we=1 exactly one cycle; then FETCH with pc+1.
REQ-027 SHALL keep we=0 in every state except MEM_WRITE.
REQ-028 SHALL, on HALT, enter HALT state, set halted=1, freeze pc/registers, ignore out_ready, remain until rst.
REQ-029 SHALL treat undefined opcodes (01xxx except h7777, 100xx, 101xx, 111xx) as NOP and pulse illegal=1 for the EXECUTE-following cycle.
REQ-030 SHALL give latencies: NOP/LI/ADD/SUB/JMP/BZ 3 cycles; STR 4; OUTR 3+wait; OUTLOC 4+wait; minimum wait 1.
REQ-031 SHALL, when ADD/LI targets a register also read by same instruction, use pre-update value.

Reset
REQ-032 SHALL, with rst high at a clock edge, set state=FETCH, pc=0, ir=0, addr=0, toMem=0, we=0, out_valid=0, out_data=0, halted=0, illegal=0, all registers 0.
REQ-033 SHALL let rst override any state including OUT_WAIT, MEM_WRITE (we drops next edge) and HALT.

Verification
REQ-034 SHALL test: mem[0]=C805 (LI r8,5), mem[1]=1008 (OUTR r8), out_ready=1 -> out_valid pulse with out_data=05 at cycle 6.
REQ-035 SHALL test: LI r1,FF; LI r2,02; ADD r1,r2 (2022); OUTR r1 -> out_data=01 (wrap, DATA_W=8).
REQ-036 SHALL test: OUTR with out_ready low 10 cycles -> out_valid held, out_data unchanged, pc unchanged until ready.
REQ-037 SHALL test: LI r3,AA; LI r4,40; STR r4->r3 (1883) -> we=1 one cycle, addr=0040, toMem=00AA.
REQ-038 SHALL test: ADDR_W=4, JMP 15 then NOP -> pc wraps 15->0; then 7777 -> halted=1, pc frozen; rst -> all outputs zero.
REQ-039 SHALL test: opcode 0x4000 -> illegal one-cycle pulse, pc advances by 1, registers unchanged.
